// File: rtl/ser2par_rx.sv
// Serial-to-parallel receiver: rebuilds MSB-first WIDTH-bit words into a one-entry valid/ready buffer.
// Optional frame counter output enabled by defining SER2PAR_FRAME_CNT_EN.
module ser2par_rx #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             e_in,
    input  logic             data_in,
    input  logic             rdy_in,
    output logic [WIDTH-1:0] data_out,
    output logic             v_out,
    output logic             busy_out,
    output logic             err_out,
    output logic             ovf_out
`ifdef SER2PAR_FRAME_CNT_EN
    ,
    output logic [7:0]       frame_cnt
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nxt;
    logic             word_done;
    logic             short_frame;
    logic [WIDTH-1:0] word;
    logic             load;
    logic             drop;

    // The completed word takes the final bit straight from the line, so it is
    // available to the buffer on the same edge that ends the frame.
    assign word = {sr[WIDTH-2:0], data_in};

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        sr_nxt      = sr;
        word_done   = 1'b0;
        short_frame = 1'b0;
        case (state)
            IDLE: begin
                if (e_in) begin
                    sr_nxt    = word;
                    cnt_nxt   = CW'(1);
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (!e_in) begin
                    short_frame = 1'b1;
                    cnt_nxt     = '0;
                    state_nxt   = IDLE;
                end else if (cnt == CW'(WIDTH - 1)) begin
                    word_done = 1'b1;
                    sr_nxt    = word;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    sr_nxt  = word;
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // A full buffer whose consumer is ready this edge frees its slot in time for the new word.
    assign load = word_done && (!v_out || rdy_in);
    assign drop = word_done && v_out && !rdy_in;

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sr    <= sr_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            data_out <= '0;
            v_out    <= 1'b0;
            err_out  <= 1'b0;
            ovf_out  <= 1'b0;
        end else begin
            err_out <= short_frame;
            if (load) begin
                data_out <= word;
                v_out    <= 1'b1;
            end else if (v_out && rdy_in) begin
                v_out <= 1'b0;
            end
            if (drop) begin
                ovf_out <= 1'b1;
            end
        end
    end

`ifdef SER2PAR_FRAME_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            frame_cnt <= '0;
        end else if (load) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

    assign busy_out = (state == SHIFT);

endmodule
